wl_afifo_rd_arb: RTL and testbench
==================================

WL_AFIFO_RD_ARB -- requirements
Module: wl_afifo_rd_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of read-side FIFO requesters.
REQ-002 SHALL have parameter BL, default 8: maximum words per burst (2..256).
REQ-003 SHALL have parameter SW, default 2: select width, equal to ceil(log2(N)).
REQ-004 SHALL have port rclk  in  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rrst_b  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port rclr  in  1  synchronous clear, same effect as reset.
REQ-007 SHALL have port rempty  in  N  per-FIFO empty flag (bit i = FIFO i).
REQ-008 SHALL have port arempty  in  N  per-FIFO almost-empty flag.
REQ-009 SHALL have port dn_rdy  in  1  downstream can accept one word this cycle.
REQ-010 SHALL have port re  out  N  one-hot (or zero) read enable to the FIFOs.
REQ-011 SHALL have port sel  out  SW  index of the granted FIFO.
REQ-012 SHALL have port busy  out  1  high while in BURST or DONE.
REQ-013 SHALL have port rvld  out  1  read data valid; re-any delayed by 1 cycle (RAM latency).
REQ-014 SHALL have port rvld_sel  out  SW  sel delayed by 1 cycle, qualifies rvld.
REQ-015 SHALL have port burst_done  out  1  one-cycle pulse, high in DONE.

Function
REQ-016 SHALL implement the states IDLE, BURST and DONE in one registered state machine.
REQ-017 SHALL define eligible[i] = ~rempty[i].
REQ-018 IDLE: if any eligible and dn_rdy=1, SHALL grant round-robin starting at ptr+1 mod N, latch sel, clear cnt, and go to BURST.
REQ-019 IDLE: SHALL hold re at 0.
REQ-020 BURST: SHALL drive re[sel] = dn_rdy & ~rempty[sel] combinationally, with all other bits 0.
REQ-021 BURST: SHALL increment the burst counter cnt (width ceil(log2(BL))+1) on each cycle re is asserted.
REQ-022 BURST: SHALL go to DONE when re is asserted with cnt=BL-1, or when rempty[sel]=1.
REQ-023 BURST: with dn_rdy=0, SHALL hold state and cnt with re=0; there is no timeout.
REQ-024 DONE: SHALL last exactly 1 cycle with re=0 and burst_done=1, set ptr=sel, then go to IDLE.
REQ-025 SHALL never assert re[i] while rempty[i]=1, so FIFO underflow is impossible.
REQ-026 SHALL never assert more than one re bit in any cycle.
REQ-027 SHALL keep sel stable from the grant until the exit from DONE.
REQ-028 Simultaneous rclr with any event: rclr SHALL win; re=0 in the cycle rclr is sampled high.

Reset
REQ-029 On rrst_b=0 or rclr=1, SHALL set: state=IDLE, cnt=0, sel=0, ptr=N-1 (FIFO 0 highest first priority), rvld=0, rvld_sel=0, burst_done=0, busy=0.
REQ-030 In reset, SHALL hold re at 0 combinationally.
REQ-031 Reset mid-burst SHALL abandon the burst; the next grant restarts from FIFO 0.

Configuration
REQ-032 With macro WL_AFIFO_ARB_PRIO_EN defined, arbitration SHALL first round-robin among FIFOs with ~rempty & ~arempty (well filled).
REQ-033 With WL_AFIFO_ARB_PRIO_EN defined, SHALL fall back to all eligible FIFOs only if that well-filled set is empty.
REQ-034 Without WL_AFIFO_ARB_PRIO_EN, arempty SHALL be ignored and arbitration SHALL be pure round-robin on eligible.

Verification
REQ-035 BL=8, FIFO0 holds 20 words, others empty, dn_rdy=1 -> bursts of 8, 8, 4 reads on re[0]; burst_done pulses 3 times; 1-cycle gap after each; rvld follows re by 1 cycle.
REQ-036 All 4 FIFOs non-empty from reset -> grant order 0, 1, 2, 3, 0; each burst is 8 reads.
REQ-037 dn_rdy=0 for 2 cycles after 3 reads of a burst -> re=0 for those cycles, cnt stays 3, burst still totals 8 reads.
REQ-038 rempty[sel] rises after 5 reads -> no further re, DONE next cycle, burst_done=1, never re while empty.
REQ-039 rclr pulse during BURST (cnt=4, sel=2) -> re=0 that cycle, then IDLE, next grant goes to FIFO0 if eligible.
REQ-040 ptr=0, FIFO1 non-empty with arempty=1, FIFO2 non-empty with arempty=0 -> grant FIFO2 with WL_AFIFO_ARB_PRIO_EN, FIFO1 without.

Source files
------------

// File: rtl/wl_afifo_rd_arb.sv
// wl_afifo_rd_arb: burst read arbiter for N asynchronous-FIFO read ports.
// Grants one non-empty FIFO round-robin and reads up to BL words from it,
// stalling on dn_rdy. Read data is valid one cycle after re (RAM latency).
// Optional build macro WL_AFIFO_ARB_PRIO_EN: prefer FIFOs that are not
// almost-empty, falling back to any non-empty FIFO.
module wl_afifo_rd_arb #(
    parameter int N  = 4,
    parameter int BL = 8,
    parameter int SW = 2
) (
    input  logic          rclk,
    input  logic          rrst_b,
    input  logic          rclr,
    input  logic [N-1:0]  rempty,
    input  logic [N-1:0]  arempty,
    input  logic          dn_rdy,
    output logic [N-1:0]  re,
    output logic [SW-1:0] sel,
    output logic          busy,
    output logic          rvld,
    output logic [SW-1:0] rvld_sel,
    output logic          burst_done
);

    localparam int CW = $clog2(BL) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] sel_q, sel_nxt;
    logic [SW-1:0] ptr, ptr_nxt;
    logic [SW-1:0] grant_idx;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  eligible, cand, re_c;
    logic          grant_vld, re_any;
    logic          rvld_p1;
    logic [SW-1:0] rvld_sel_p1;

    assign eligible = ~rempty;

`ifdef WL_AFIFO_ARB_PRIO_EN
    logic [N-1:0] well;
    assign well = ~rempty & ~arempty;
    assign cand = (|well) ? well : eligible;
`else
    logic unused_arempty;
    assign unused_arempty = ^arempty;
    assign cand = eligible;
`endif

    // Round-robin pick: first candidate at ptr+1, ptr+2, ... wrapping mod N.
    always_comb begin
        logic [SW-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = N; k >= 1; k--) begin
            idx = SW'((int'(ptr) + k) % N);
            if (cand[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Read enable: only the granted FIFO, only if it has data and downstream is ready.
    always_comb begin
        re_c = '0;
        if (rrst_b && !rclr && state == BURST && dn_rdy && !rempty[sel_q])
            re_c[sel_q] = 1'b1;
    end

    assign re_any = |re_c;

    // Next-state and next control values for the burst sequencer.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (grant_vld && dn_rdy) begin
                    sel_nxt   = grant_idx;
                    cnt_nxt   = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (re_any)
                    cnt_nxt = cnt + CW'(1);
                if ((re_any && cnt == CNT_LAST) || rempty[sel_q])
                    state_nxt = DONE;
            end
            DONE: begin
                ptr_nxt   = sel_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; clear behaves exactly like reset.
    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b)
            state <= IDLE;
        else if (rclr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Grant index, burst counter and round-robin pointer (FIFO 0 first after reset).
    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b) begin
            sel_q <= '0;
            cnt   <= '0;
            ptr   <= SW'(N - 1);
        end else if (rclr) begin
            sel_q <= '0;
            cnt   <= '0;
            ptr   <= SW'(N - 1);
        end else begin
            sel_q <= sel_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Read-data valid and its source index trail re by one RAM cycle.
    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b) begin
            rvld_p1     <= 1'b0;
            rvld_sel_p1 <= '0;
        end else if (rclr) begin
            rvld_p1     <= 1'b0;
            rvld_sel_p1 <= '0;
        end else begin
            rvld_p1     <= re_any;
            rvld_sel_p1 <= sel_q;
        end
    end

    assign re         = re_c;
    assign sel        = sel_q;
    assign busy       = (state != IDLE);
    assign burst_done = (state == DONE);
    assign rvld       = rvld_p1;
    assign rvld_sel   = rvld_sel_p1;

endmodule

// File: tb/tb_wl_afifo_rd_arb.sv
// Testbench for wl_afifo_rd_arb: FIFO occupancy model drives rempty/arempty,
// a burst-level reference predicts grant order and burst lengths, and a
// negedge monitor checks reads and burst completions against the queues.
module tb_wl_afifo_rd_arb;
    localparam int N  = 4;
    localparam int BL = 8;
    localparam int SW = 2;
    localparam int AE = 2;   // almost-empty when a FIFO holds AE words or fewer

    logic          rclk = 1'b0;
    logic          rrst_b = 1'b0;
    logic          rclr = 1'b0;
    logic [N-1:0]  rempty = '1;
    logic [N-1:0]  arempty = '1;
    logic          dn_rdy = 1'b0;
    logic [N-1:0]  re;
    logic [SW-1:0] sel;
    logic          busy;
    logic          rvld;
    logic [SW-1:0] rvld_sel;
    logic          burst_done;

    int            fifo_cnt[N] = '{0, 0, 0, 0};
    int            dn_pct = 100;
    logic [N-1:0]  re_s = '0;
    bit            mon_en = 1'b0;
    bit            prev_re_any = 1'b0;
    int            burst_reads = 0;
    int            mptr = N - 1;
    int            checks = 0;
    int            errors = 0;
    int            rd_q[$];
    int            bq_fifo[$];
    int            bq_len[$];

    wl_afifo_rd_arb #(.N(N), .BL(BL), .SW(SW)) dut (
        .rclk       (rclk),
        .rrst_b     (rrst_b),
        .rclr       (rclr),
        .rempty     (rempty),
        .arempty    (arempty),
        .dn_rdy     (dn_rdy),
        .re         (re),
        .sel        (sel),
        .busy       (busy),
        .rvld       (rvld),
        .rvld_sel   (rvld_sel),
        .burst_done (burst_done)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Burst-level reference: from the current occupancies, list every burst
    // the arbiter must perform until all FIFOs are drained.
    task automatic model_run();
        int c[N];
        for (int i = 0; i < N; i++) c[i] = fifo_cnt[i];
        forever begin
            bit cand[N];
            bit any_elig, any_well;
            int g, len;
            any_elig = 0;
            any_well = 0;
            for (int i = 0; i < N; i++) begin
                if (c[i] > 0) any_elig = 1;
                if (c[i] > AE) any_well = 1;
            end
            if (!any_elig) break;
            for (int i = 0; i < N; i++) begin
`ifdef WL_AFIFO_ARB_PRIO_EN
                cand[i] = any_well ? (c[i] > AE) : (c[i] > 0);
`else
                cand[i] = (c[i] > 0);
`endif
            end
            g = -1;
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && cand[(mptr + k) % N]) g = (mptr + k) % N;
            end
            len = (c[g] < BL) ? c[g] : BL;
            for (int j = 0; j < len; j++) rd_q.push_back(g);
            bq_fifo.push_back(g);
            bq_len.push_back(len);
            c[g] -= len;
            mptr = g;
        end
    endtask

    // FIFO side: consume a word for each read seen last cycle, refresh flags, randomize dn_rdy.
    initial begin
        forever begin
            @(posedge rclk);
            #1;
            for (int i = 0; i < N; i++)
                if (re_s[i] && fifo_cnt[i] > 0) fifo_cnt[i]--;
            for (int i = 0; i < N; i++) begin
                rempty[i]  = (fifo_cnt[i] == 0);
                arempty[i] = (fifo_cnt[i] <= AE);
            end
            dn_rdy = ($urandom_range(99) < dn_pct);
        end
    end

    // Monitor: per-cycle safety checks and scoreboard pops.
    initial begin
        forever begin
            @(negedge rclk);
            re_s = re;
            if (mon_en) begin
                if (re != '0) begin
                    chk("re_onehot", $countones(re), 1);
                    chk("re_is_sel", int'(re), 1 << sel);
                    chk("re_while_empty", int'(re & rempty), 0);
                    chk("busy_during_read", int'(busy), 1);
                    burst_reads++;
                end
                if (burst_done) chk("done_re_zero", int'(re), 0);
                chk("rvld_delay", int'(rvld), int'(prev_re_any));
                if (rvld) begin
                    if (rd_q.size() == 0) chk("rvld_extra", int'(rvld), 0);
                    else chk("rvld_sel", int'(rvld_sel), rd_q.pop_front());
                end
                if (burst_done) begin
                    if (bq_fifo.size() == 0) chk("done_extra", int'(burst_done), 0);
                    else begin
                        chk("burst_sel", int'(sel), bq_fifo.pop_front());
                        chk("burst_len", burst_reads, bq_len.pop_front());
                    end
                    burst_reads = 0;
                end
            end else begin
                burst_reads = 0;
            end
            prev_re_any = |re;
        end
    end

    task automatic run_phase(input int a, input int b, input int c, input int d, input int pct);
        int left;
        @(posedge rclk);
        #2;
        fifo_cnt = '{a, b, c, d};
        dn_pct = pct;
        model_run();
        for (int t = 0; t < 3000; t++) begin
            @(negedge rclk);
            if (rd_q.size() == 0 && bq_fifo.size() == 0 && !busy) break;
        end
        repeat (2) @(negedge rclk);
        chk("phase_pending", rd_q.size() + bq_fifo.size(), 0);
        chk("phase_idle", int'(busy), 0);
        left = 0;
        for (int i = 0; i < N; i++) left += fifo_cnt[i];
        chk("phase_words_left", left, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with data present and downstream ready: outputs must stay quiet.
        fifo_cnt = '{5, 5, 5, 5};
        dn_pct = 100;
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        chk("rst_re", int'(re), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(burst_done), 0);
        chk("rst_rvld", int'(rvld), 0);
        chk("rst_rvld_sel", int'(rvld_sel), 0);
        fifo_cnt = '{0, 0, 0, 0};
        @(posedge rclk);
        @(negedge rclk);
        rrst_b = 1'b1;
        mptr = N - 1;
        mon_en = 1'b1;

        run_phase(16, 8, 8, 8, 100);   // order 0,1,2,3,0
        run_phase(0, 2, 10, 0, 100);   // ptr=0: almost-empty FIFO1 vs well-filled FIFO2
        run_phase(20, 0, 0, 0, 100);   // bursts 8,8,4 on FIFO0
        run_phase(5, 0, 0, 0, 60);
        for (int r = 0; r < 10; r++)
            run_phase($urandom_range(20), $urandom_range(20), $urandom_range(20),
                      $urandom_range(20), $urandom_range(100, 30));

        // Synchronous clear in the middle of a FIFO2 burst.
        mon_en = 1'b0;
        @(posedge rclk);
        #2;
        rclr = 1'b1;
        @(posedge rclk);
        #2;
        rclr = 1'b0;
        fifo_cnt = '{20, 8, 8, 0};
        dn_pct = 100;
        for (int t = 0; t < 200; t++) begin
            @(posedge rclk);
            #2;
            if (busy && sel == 2 && fifo_cnt[2] == 4) break;
        end
        chk("rclr_setup_sel", int'(sel), 2);
        chk("rclr_setup_cnt", fifo_cnt[2], 4);
        rclr = 1'b1;
        #1;
        chk("rclr_re_zero", int'(re), 0);
        @(posedge rclk);
        #2;
        rclr = 1'b0;
        #1;
        chk("rclr_busy", int'(busy), 0);
        chk("rclr_sel", int'(sel), 0);
        chk("rclr_done", int'(burst_done), 0);
        chk("rclr_no_read", fifo_cnt[2], 4);
        for (int t = 0; t < 20; t++) begin
            @(negedge rclk);
            if (re != '0) break;
        end
        chk("rclr_next_grant", int'(re), 1);

        // Asynchronous reset in the middle of that burst.
        @(posedge rclk);
        #3;
        rrst_b = 1'b0;
        #1;
        chk("arst_re", int'(re), 0);
        chk("arst_sel", int'(sel), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_rvld", int'(rvld), 0);
        fifo_cnt = '{0, 0, 0, 0};
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst_b = 1'b1;
        mptr = N - 1;
        mon_en = 1'b1;
        run_phase(4, 4, 0, 0, 100);    // restarts at FIFO0

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
